// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared types and helpers for the multi-port register file.
//          Holds the clear-sequencer state encoding, default geometry and
//          the address-range check used by both write ports.
// Rev    : 1.0  initial release
// ============================================================================
package regfile_pkg;

  // Clear sequencer states; explicit 1-bit encoding.
  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int unsigned RF_DEF_WIDTH = 32;
  localparam int unsigned RF_DEF_DEPTH = 32;

  // True when an address selects a physically present entry. Needed because
  // DEPTH need not be a power of two, so the address bus can exceed it.
  function automatic logic rf_addr_valid(input logic [31:0] addr,
                                         input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rf_clear_seq.sv
`default_nettype none
// ============================================================================
// Module : rf_clear_seq
// Brief  : Bulk-clear sweep engine. On clr_req in IDLE it walks a pointer
//          from 0 to DEPTH-1, one entry per cycle, raising busy for exactly
//          DEPTH cycles. Requests while sweeping are ignored (no queueing).
// Ports  : clk, rst          - clock / synchronous active-high reset
//          clr_req           - start a sweep (sampled in IDLE only)
//          busy              - sweep in progress
//          clr_we            - zero-write strobe for entry clr_ptr
//          clr_ptr[AW]       - entry being cleared this cycle
// Rev    : 1.0  initial release
// ============================================================================
module rf_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_ptr
);

  // Terminal compare against DEPTH-1 (not a wrap) so non-power-of-2 depths
  // stop exactly on the last present entry.
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = RF_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = RF_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign busy    = (state_q == RF_CLEAR);
  assign clr_we  = busy;
  assign clr_ptr = ptr_q;

endmodule : rf_clear_seq
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module : reg_file_mp
// Brief  : Parametrised register file with NRD combinational read ports,
//          two write ports (B has priority over A on the same address),
//          optional hardwired-zero entry 0, optional write-to-read bypass
//          and a sequenced bulk clear with busy handshake.
// Ports  : clk, rst              - clock / synchronous active-high reset
//          rd_addr[NRD*AW]       - packed read addresses, port k at k*AW
//          rd_data[NRD*WIDTH]    - packed read data, port k at k*WIDTH
//          wa_en/wa_addr/wa_data - write port A
//          wb_en/wb_addr/wb_data - write port B (wins collisions)
//          clr_req               - request bulk clear
//          busy                  - clear sweep running
//          wr_drop               - an enabled write was discarded last cycle
// Rev    : 1.0  initial release
// ============================================================================
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = RF_DEF_WIDTH,
  parameter int unsigned DEPTH    = RF_DEF_DEPTH,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned NRD      = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  input  logic                 wa_en,
  input  logic [AW-1:0]        wa_addr,
  input  logic [WIDTH-1:0]     wa_data,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [WIDTH-1:0]     wb_data,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 wr_drop
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic          clr_we;
  logic [AW-1:0] clr_ptr;

  logic wa_valid, wb_valid;
  logic wa_zero, wb_zero;
  logic wa_ok, wb_ok;
  logic wr_drop_d, wr_drop_q;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_ptr (clr_ptr)
  );

  // ---------------------------------------------------------------------------
  // Write qualification. Writes to entry 0 with ZERO_REG are ignored quietly;
  // only busy or out-of-range targets count as drops.
  // ---------------------------------------------------------------------------
  assign wa_valid = rf_addr_valid(32'(wa_addr), DEPTH);
  assign wb_valid = rf_addr_valid(32'(wb_addr), DEPTH);
  assign wa_zero  = ZERO_REG && (wa_addr == '0);
  assign wb_zero  = ZERO_REG && (wb_addr == '0);
  assign wa_ok    = wa_en && !busy && wa_valid && !wa_zero;
  assign wb_ok    = wb_en && !busy && wb_valid && !wb_zero;

  assign wr_drop_d = (wa_en && (busy || !wa_valid)) ||
                     (wb_en && (busy || !wb_valid));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= wr_drop_d;
    end
  end

  assign wr_drop = wr_drop_q;

  // ---------------------------------------------------------------------------
  // Storage. Sweep writes and port writes are mutually exclusive because the
  // ports are blocked while busy; B is checked before A to give it priority.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem_q[i] <= '0;
      end else if (clr_we && (clr_ptr == AW'(i))) begin
        mem_q[i] <= '0;
      end else if (wb_ok && (wb_addr == AW'(i))) begin
        mem_q[i] <= wb_data;
      end else if (wa_ok && (wa_addr == AW'(i))) begin
        mem_q[i] <= wa_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports. The decode loop leaves out-of-range addresses at zero.
  // Bypass reuses the write qualifiers, so it never fires while busy or onto
  // the hardwired-zero entry.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rval;

    assign raddr = rd_addr[k*AW +: AW];

    always_comb begin
      rval = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (raddr == AW'(j)) begin
          rval = mem_q[j];
        end
      end
      if (ZERO_REG && (raddr == '0)) begin
        rval = '0;
      end else if (BYPASS) begin
        if (wb_ok && (wb_addr == raddr)) begin
          rval = wb_data;
        end else if (wa_ok && (wa_addr == raddr)) begin
          rval = wa_data;
        end
      end
    end

    assign rd_data[k*WIDTH +: WIDTH] = rval;
  end

endmodule : reg_file_mp
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module : tb_reg_file_mp
// Brief  : Directed self-checking bench for reg_file_mp. Two instances share
//          all inputs: one with bypass enabled, one without.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reg_file_mp;

  localparam int W = 32;
  localparam int D = 32;
  localparam int A = 5;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N*A-1:0] rd_addr;
  logic [N*W-1:0] rd_data, rd_data_nb;
  logic         wa_en, wb_en;
  logic [A-1:0] wa_addr, wb_addr;
  logic [W-1:0] wa_data, wb_data;
  logic         clr_req;
  logic         busy, busy_nb;
  logic         wr_drop, wr_drop_nb;

  int n_chk = 0;
  int n_err = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  reg_file_mp #(
    .WIDTH(W), .DEPTH(D), .AW(A), .NRD(N), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .clr_req(clr_req), .busy(busy), .wr_drop(wr_drop)
  );

  reg_file_mp #(
    .WIDTH(W), .DEPTH(D), .AW(A), .NRD(N), .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) u_dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .clr_req(clr_req), .busy(busy_nb), .wr_drop(wr_drop_nb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [A-1:0] a, input logic [W-1:0] d);
    wa_en = 1'b1; wa_addr = a; wa_data = d;
    tick();
    wa_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rd_addr = '0; clr_req = 1'b0;
    wa_en = 1'b0; wa_addr = '0; wa_data = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    tick(); tick();
    rst = 1'b0;

    // Garbage preload through port B, then a single reset cycle.
    for (int i = 1; i < D; i++) begin
      wb_en = 1'b1; wb_addr = A'(i); wb_data = 32'h5A5A_0000 | i;
      tick();
    end
    wb_en = 1'b0;
    rd_addr[4:0] = 5'd3; #1;
    chk("preload", rd_data[31:0], 32'h5A5A_0003);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int a = 0; a < D; a++) begin
      rd_addr = {A'(a), A'(a)}; #1;
      chk("rst_rd0", rd_data[31:0], 32'h0);
      chk("rst_rd1", rd_data[63:32], 32'h0);
    end
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_drop", {31'b0, wr_drop}, 32'h0);

    // Basic write with same-cycle bypass vs. no bypass.
    wa_en = 1'b1; wa_addr = 5'd5; wa_data = 32'hDEAD_BEEF;
    rd_addr[4:0] = 5'd5; #1;
    chk("byp_same", rd_data[31:0], 32'hDEAD_BEEF);
    chk("nobyp_same", rd_data_nb[31:0], 32'h0);
    tick(); wa_en = 1'b0; #1;
    chk("wr_next", rd_data[31:0], 32'hDEAD_BEEF);
    chk("wr_next_nb", rd_data_nb[31:0], 32'hDEAD_BEEF);

    // Collision: B wins, both in bypass and storage; no drop.
    wa_en = 1'b1; wa_addr = 5'd7; wa_data = 32'h1111_1111;
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h2222_2222;
    rd_addr[9:5] = 5'd7; #1;
    chk("coll_byp", rd_data[63:32], 32'h2222_2222);
    tick(); wa_en = 1'b0; wb_en = 1'b0; #1;
    chk("coll_mem", rd_data[63:32], 32'h2222_2222);
    chk("coll_mem_nb", rd_data_nb[63:32], 32'h2222_2222);
    chk("coll_drop", {31'b0, wr_drop}, 32'h0);

    // Hardwired zero entry.
    wa_en = 1'b1; wa_addr = 5'd0; wa_data = 32'hFFFF_FFFF;
    rd_addr[4:0] = 5'd0; #1;
    chk("zero_byp", rd_data[31:0], 32'h0);
    tick(); wa_en = 1'b0; #1;
    chk("zero_mem", rd_data[31:0], 32'h0);
    chk("zero_drop", {31'b0, wr_drop}, 32'h0);

    // Fill, then bulk clear with a dropped write and an ignored request.
    for (int i = 1; i < D; i++) wr_a(A'(i), 32'h1000_0000 | i);
    rd_addr[4:0] = 5'd31; #1;
    chk("fill31", rd_data[31:0], 32'h1000_001F);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    chk("busy_rise", {31'b0, busy}, 32'h1);
    busy_cnt = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      busy_cnt++;
      wa_en = (c == 2); wa_addr = 5'd9; wa_data = 32'h9999_9999;
      clr_req = (c == 5);
      rd_addr[4:0] = (c == 6) ? 5'd20 : 5'd9;
      rd_addr[9:5] = 5'd2;
      #1;
      if (c == 2) chk("busy_no_byp", rd_data[31:0], 32'h1000_0009);
      if (c == 3) chk("drop_pulse", {31'b0, wr_drop}, 32'h1);
      if (c == 4) chk("drop_once", {31'b0, wr_drop}, 32'h0);
      if (c == 5) chk("partial_lo", rd_data[63:32], 32'h0);
      if (c == 6) chk("partial_hi", rd_data[31:0], 32'h1000_0014);
      tick();
    end
    wa_en = 1'b0; clr_req = 1'b0;
    chk("busy_len", busy_cnt, 32);
    for (int a = 0; a < D; a++) begin
      rd_addr[4:0] = A'(a); #1;
      chk("clr_rd", rd_data[31:0], 32'h0);
    end
    tick();
    chk("no_queue", {31'b0, busy}, 32'h0);

    // Reset in the middle of a sweep, then restart from pointer 0.
    wr_a(5'd3, 32'hAAAA_0003);
    wr_a(5'd30, 32'hAAAA_001E);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    rd_addr = {5'd3, 5'd30}; #1;
    chk("mid_rst_e30", rd_data[31:0], 32'h0);
    chk("mid_rst_e3", rd_data[63:32], 32'h0);

    wr_a(5'd1, 32'h0000_0111);
    wr_a(5'd31, 32'h0000_0F1F);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40 && busy; c++) begin
      busy_cnt++;
      rd_addr[4:0] = 5'd1; #1;
      if (c == 1) chk("restart_e1_old", rd_data[31:0], 32'h0000_0111);
      if (c == 2) chk("restart_e1_clr", rd_data[31:0], 32'h0);
      tick();
    end
    chk("restart_len", busy_cnt, 32);
    rd_addr[4:0] = 5'd31; #1;
    chk("restart_e31", rd_data[31:0], 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_reg_file_mp
`default_nettype wire
